voice_mix_sequencer: RTL

VOICE_MIX_SEQUENCER -- requirements
Module: voice_mix_sequencer

---
 rtl/voice_mix_sequencer.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/voice_mix_sequencer.sv
// ---------------------------------------------------------------------------
// voice_mix_sequencer
//
// Mixes up to C_VOICES sample/gain pairs into one frame sum. For every
// enabled voice the operands are handed to an external shift-add multiplier.
// The product it returns is added to a wrapping C_WIDTH accumulator. A voice
// whose product never arrives is abandoned after C_TIMEOUT wait cycles, and
// the sticky err flag is raised.
//
// Ports
//   ctl_clk      in   clock, rising edge
//   reset        in   synchronous, active-high
//   start        in   frame request, only looked at while idle
//   samples      in   C_VOICES*C_WIDTH, voice i at [i*C_WIDTH +: C_WIDTH]
//   gains        in   C_VOICES*C_WIDTH, packed like samples
//   voice_en     in   C_VOICES per-voice enables
//   busy         out  high whenever the sequencer is not idle
//   mix_out      out  last completed frame sum, held between frames
//   mix_valid    out  one-cycle frame-complete strobe
//   err          out  sticky multiplier-timeout flag
//   mul_a/mul_b  out  multiplier operands
//   mul_trigger  out  operand-valid strobe
//   mul_ready    in   multiplier can accept operands
//   mul_done     in   one-cycle product-valid pulse
//   mul_y        in   product, low C_WIDTH bits
//   dbg_state    out  current FSM state encoding
//   dbg_index    out  current voice index
//
// Multiplier handshake: operands are offered with mul_trigger=1. They are
// taken on the rising edge where mul_trigger and mul_ready are both 1. The
// product is accepted only while waiting, on the edge where mul_done=1.
// mul_a/mul_b do not change from the offer until the wait ends.
// ---------------------------------------------------------------------------
module voice_mix_sequencer #(
  parameter int C_WIDTH   = 32,
  parameter int C_VOICES  = 4,
  parameter int C_TIMEOUT = 255
) (
  input  logic                          ctl_clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [C_VOICES*C_WIDTH-1:0]   samples,
  input  logic [C_VOICES*C_WIDTH-1:0]   gains,
  input  logic [C_VOICES-1:0]           voice_en,
  output logic                          busy,
  output logic [C_WIDTH-1:0]            mix_out,
  output logic                          mix_valid,
  output logic                          err,
  output logic [C_WIDTH-1:0]            mul_a,
  output logic [C_WIDTH-1:0]            mul_b,
  output logic                          mul_trigger,
  input  logic                          mul_ready,
  input  logic                          mul_done,
  input  logic [C_WIDTH-1:0]            mul_y,
  output logic [2:0]                    dbg_state,
  output logic [$clog2(C_VOICES+1)-1:0] dbg_index
);

  localparam int IW = $clog2(C_VOICES + 1);
  localparam int TW = (C_TIMEOUT > 1) ? $clog2(C_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               r_state;
  logic [IW-1:0]        r_idx;
  logic [C_WIDTH-1:0]   r_acc;
  logic [C_WIDTH-1:0]   r_mix_out;
  logic                 r_mix_valid;
  logic                 r_err;
  logic [C_WIDTH-1:0]   r_mul_a;
  logic [C_WIDTH-1:0]   r_mul_b;
  logic                 r_mul_trigger;
  logic [TW-1:0]        r_tcnt;

  // Frame snapshot. Input changes after start cannot disturb a running frame.
  logic [C_WIDTH-1:0]   r_sample [C_VOICES];
  logic [C_WIDTH-1:0]   r_gain   [C_VOICES];
  logic [C_VOICES-1:0]  r_en;

  logic [C_WIDTH-1:0]   w_cur_sample;
  logic [C_WIDTH-1:0]   w_cur_gain;
  logic                 w_cur_en;
  logic                 w_last;
  logic [TW-1:0]        w_tcnt_inc;

  // r_idx reaches C_VOICES, which is one past the last voice, so the
  // selection is a compare-based mux rather than a direct array index.
  always_comb begin
    w_cur_sample = '0;
    w_cur_gain   = '0;
    w_cur_en     = 1'b0;
    for (int i = 0; i < C_VOICES; i++) begin
      if (r_idx == IW'(i)) begin
        w_cur_sample = r_sample[i];
        w_cur_gain   = r_gain[i];
        w_cur_en     = r_en[i];
      end
    end
  end

  assign w_last     = (r_idx == IW'(C_VOICES));
  assign w_tcnt_inc = r_tcnt + TW'(1);

  always_ff @(posedge ctl_clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_acc         <= '0;
      r_mix_out     <= '0;
      r_mix_valid   <= 1'b0;
      r_err         <= 1'b0;
      r_mul_a       <= '0;
      r_mul_b       <= '0;
      r_mul_trigger <= 1'b0;
      r_tcnt        <= '0;
      r_en          <= '0;
      for (int i = 0; i < C_VOICES; i++) begin
        r_sample[i] <= '0;
        r_gain[i]   <= '0;
      end
    end else begin
      r_mix_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < C_VOICES; i++) begin
              r_sample[i] <= samples[i*C_WIDTH +: C_WIDTH];
              r_gain[i]   <= gains[i*C_WIDTH +: C_WIDTH];
            end
            r_en    <= voice_en;
            r_idx   <= '0;
            r_acc   <= '0;
            r_tcnt  <= '0;
            r_err   <= 1'b0;
            r_state <= S_SCAN;
          end
        end

        S_SCAN: begin
          if (w_last) begin
            r_mix_out <= r_acc;
            r_state   <= S_DONE;
          end else if (!w_cur_en) begin
            r_idx <= r_idx + IW'(1);
          end else begin
            // Operands are loaded here and left alone until the next voice
            // is offered, so they stay stable through the whole wait.
            r_mul_a       <= w_cur_sample;
            r_mul_b       <= w_cur_gain;
            r_mul_trigger <= 1'b1;
            r_state       <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (mul_ready) begin
            r_mul_trigger <= 1'b0;
            r_state       <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (mul_done) begin
            r_acc   <= r_acc + mul_y;
            r_idx   <= r_idx + IW'(1);
            r_tcnt  <= '0;
            r_state <= S_SCAN;
          end else if (w_tcnt_inc == TW'(C_TIMEOUT)) begin
            // Abandon the voice. Its product is not added to the sum.
            r_err   <= 1'b1;
            r_idx   <= r_idx + IW'(1);
            r_tcnt  <= '0;
            r_state <= S_SCAN;
          end else begin
            r_tcnt <= w_tcnt_inc;
          end
        end

        S_DONE: begin
          // The strobe is registered out of DONE. It shows up in the cycle
          // after DONE, which is also the first idle cycle. mix_out was
          // already loaded on the way into DONE.
          r_mix_valid <= 1'b1;
          r_state     <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign mix_out     = r_mix_out;
  assign mix_valid   = r_mix_valid;
  assign err         = r_err;
  assign mul_a       = r_mul_a;
  assign mul_b       = r_mul_b;
  assign mul_trigger = r_mul_trigger;
  assign dbg_state   = r_state;
  assign dbg_index   = r_idx;

endmodule
